bus_seq: RTL and testbench

BUS_SEQ -- requirements
Module: bus_seq

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_seq_mm.sv | 32 +++
 rtl/bus_seq.sv | 166 ++++++++++++++++
 tb/tb_bus_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants for the CPU bus sequencer: device module IDs, FSM encoding, error data.
package bus_pkg;
  localparam int MOD_W = 4;
  typedef logic [MOD_W-1:0] mod_t;

  localparam mod_t MOD_ROM      = 4'd0;
  localparam mod_t MOD_RAM      = 4'd1;
  localparam mod_t MOD_UART     = 4'd2;
  localparam mod_t MOD_SWITCHES = 4'd3;
  localparam mod_t MOD_LEDS     = 4'd4;
  localparam mod_t MOD_VGA      = 4'd5;
  localparam mod_t MOD_PLPID    = 4'd8;
  localparam mod_t MOD_TIMER    = 4'd9;
  localparam mod_t MOD_SSEG     = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA = 32'h0000_0000;
endpackage

// File: rtl/bus_seq_mm.sv
// Address decoder: CPU address -> device module ID and module-relative address.
// RAM keeps the low 24 bits, I/O windows the low 20; ROM and anything unmapped map to ID 0.
module mm
  import bus_pkg::*;
(
  input  logic [31:0] addr,
  output mod_t        mod,
  output logic [31:0] eff_addr
);

  always_comb begin
    mod      = MOD_ROM;
    eff_addr = addr;
    if (addr[31:24] == 8'h10) begin
      mod      = MOD_RAM;
      eff_addr = {8'h00, addr[23:0]};
    end else if (addr[31:28] == 4'hF) begin
      case (addr[27:20])
        8'h00:   mod = MOD_UART;
        8'h01:   mod = MOD_SWITCHES;
        8'h02:   mod = MOD_LEDS;
        8'h04:   mod = MOD_VGA;
        8'h05:   mod = MOD_PLPID;
        8'h06:   mod = MOD_TIMER;
        8'h0A:   mod = MOD_SSEG;
        default: mod = MOD_ROM;
      endcase
      if (mod != MOD_ROM) eff_addr = {12'h000, addr[19:0]};
    end
  end

endmodule

// File: rtl/bus_seq.sv
// CPU-to-device bus sequencer: IDLE -> REQ -> WAIT -> DONE, one-hot select, single-cycle strobes.
// Optional WAIT timeout with bus_err pulse when BUS_TIMEOUT_EN is defined.
module bus_seq
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int NDEV           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  output logic [NDEV-1:0]      dev_sel,
  output logic                 dev_rd,
  output logic                 dev_wr,
  output logic [31:0]          dev_addr,
  output logic [31:0]          dev_wdata,
  input  logic [NDEV*32-1:0]   dev_rdata,
  input  logic [NDEV-1:0]      dev_ready,
  output logic                 bus_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (NDEV <= int'(MOD_SSEG)) begin : g_bad_ndev
    $error("NDEV must cover every mapped module ID");
  end

  mod_t        w_mod;
  logic [31:0] w_eff;

  mm u_mm (
    .addr     (cpu_addr),
    .mod      (w_mod),
    .eff_addr (w_eff)
  );

  state_t          r_state;
  mod_t            r_id;
  logic            r_is_wr;
  logic [NDEV-1:0] r_sel;
  logic            r_rd;
  logic            r_wr;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;

  logic [NDEV-1:0] w_id_oh;
  logic [NDEV-1:0] w_req_oh;
  logic [31:0]     w_rdata;
  logic            w_ready;
  logic            w_req;
  logic            w_null_wr;

  always_comb begin
    w_id_oh  = '0;
    w_req_oh = '0;
    w_rdata  = '0;
    for (int i = 0; i < NDEV; i++) begin
      w_id_oh[i]  = (int'(r_id) == i);
      w_req_oh[i] = (int'(w_mod) == i);
      w_rdata     = w_rdata | (dev_rdata[32*i +: 32] & {32{w_id_oh[i]}});
    end
  end

  // Only the latched slot's ready counts; other devices may be asserting theirs.
  assign w_ready   = |(dev_ready & w_id_oh);
  assign w_req     = cpu_rd | cpu_wr;
  assign w_null_wr = cpu_wr & (w_mod == MOD_ROM);

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_id    <= MOD_ROM;
      r_is_wr <= 1'b0;
      r_sel   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
      r_tmo   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_id    <= w_mod;
            r_is_wr <= cpu_wr;
            r_addr  <= w_eff;
            r_wdata <= cpu_wdata;
            r_sel   <= w_null_wr ? '0 : w_req_oh;
            r_rd    <= ~cpu_wr;
            r_wr    <= cpu_wr & ~w_null_wr;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_rd <= 1'b0;
          r_wr <= 1'b0;
`ifdef BUS_TIMEOUT_EN
          r_tmo <= '0;
`endif
          // ROM is read-only: a store there completes without touching the bus.
          if (r_is_wr && (r_id == MOD_ROM)) begin
            r_sel   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_ready) begin
            if (!r_is_wr) r_rdata <= w_rdata;
            r_sel   <= '0;
            r_state <= ST_DONE;
          end
`ifdef BUS_TIMEOUT_EN
          else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_rdata <= ERR_DATA;
            r_err   <= 1'b1;
            r_sel   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
`endif
        end
        ST_DONE: begin
`ifdef BUS_TIMEOUT_EN
          r_err <= 1'b0;
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_stall = w_req & (r_state != ST_DONE) & ~rst;
  assign cpu_rdata = r_rdata;
  assign dev_sel   = r_sel;
  assign dev_rd    = r_rd;
  assign dev_wr    = r_wr;
  assign dev_addr  = r_addr;
  assign dev_wdata = r_wdata;
`ifdef BUS_TIMEOUT_EN
  assign bus_err   = r_err;
`else
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_seq.sv
// Directed bench for bus_seq: loads, stores, ROM store, slot filtering, timeout/stall, reset abort.
module tb_bus_seq;
  localparam int NDEV = 16;

  logic              clk;
  logic              rst;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic [NDEV-1:0]   dev_sel;
  logic              dev_rd;
  logic              dev_wr;
  logic [31:0]       dev_addr;
  logic [31:0]       dev_wdata;
  logic [NDEV*32-1:0] dev_rdata;
  logic [NDEV-1:0]   dev_ready;
  logic              bus_err;

  int n_chk  = 0;
  int n_pass = 0;

  bus_seq #(.TIMEOUT_CYCLES(4), .NDEV(NDEV)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dev_sel   (dev_sel),
    .dev_rd    (dev_rd),
    .dev_wr    (dev_wr),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .dev_ready (dev_ready),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b1; cpu_wr = 1'b0;
    dev_rdata = '0; dev_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall",  32'(cpu_stall), 32'h0);
    chk("rst_sel",    32'(dev_sel),   32'h0);
    chk("rst_rd",     32'(dev_rd),    32'h0);
    chk("rst_wr",     32'(dev_wr),    32'h0);
    chk("rst_rdata",  cpu_rdata,      32'h0);
    chk("rst_addr",   dev_addr,       32'h0);
    chk("rst_wdata",  dev_wdata,      32'h0);
    chk("rst_err",    32'(bus_err),   32'h0);
    cpu_rd = 1'b0; rst = 1'b0;
    step();

    // RAM load, ready already up for the first WAIT cycle
    cpu_addr = 32'h1000_0040; cpu_rd = 1'b1;
    dev_rdata[32*1 +: 32] = 32'h1234_5678; dev_ready = 16'h0002;
    #1;
    chk("ld_idle_stall", 32'(cpu_stall), 32'h1);
    step();
    chk("ld_req_sel",   32'(dev_sel),   32'h0002);
    chk("ld_req_rd",    32'(dev_rd),    32'h1);
    chk("ld_req_wr",    32'(dev_wr),    32'h0);
    chk("ld_req_addr",  dev_addr,       32'h0000_0040);
    chk("ld_req_stall", 32'(cpu_stall), 32'h1);
    step();
    chk("ld_wait_rd",    32'(dev_rd),    32'h0);
    chk("ld_wait_sel",   32'(dev_sel),   32'h0002);
    chk("ld_wait_stall", 32'(cpu_stall), 32'h1);
    step();
    chk("ld_done_stall", 32'(cpu_stall), 32'h0);
    chk("ld_done_rdata", cpu_rdata,      32'h1234_5678);
    chk("ld_done_sel",   32'(dev_sel),   32'h0);
    cpu_rd = 1'b0; dev_ready = '0;
    step();
    chk("ld_hold_rdata", cpu_rdata, 32'h1234_5678);

    // LED store
    cpu_addr = 32'hF020_0000; cpu_wdata = 32'h0000_00A5; cpu_wr = 1'b1;
    step();
    chk("st_req_wr",    32'(dev_wr),  32'h1);
    chk("st_req_sel",   32'(dev_sel), 32'h0010);
    chk("st_req_wdata", dev_wdata,    32'h0000_00A5);
    chk("st_req_addr",  dev_addr,     32'h0);
    step();
    chk("st_wait_wr",    32'(dev_wr),    32'h0);
    chk("st_wait_stall", 32'(cpu_stall), 32'h1);
    dev_ready = 16'h0010;
    step();
    chk("st_done_stall", 32'(cpu_stall), 32'h0);
    chk("st_rdata_kept", cpu_rdata,      32'h1234_5678);
    cpu_wr = 1'b0; dev_ready = '0;
    step();

    // Store to ROM: no strobe, DONE two cycles after acceptance
    cpu_addr = 32'h0000_0010; cpu_wdata = 32'h77; cpu_wr = 1'b1;
    step();
    chk("rom_req_wr",    32'(dev_wr),    32'h0);
    chk("rom_req_sel",   32'(dev_sel),   32'h0);
    chk("rom_req_stall", 32'(cpu_stall), 32'h1);
    step();
    chk("rom_done_stall", 32'(cpu_stall), 32'h0);
    cpu_wr = 1'b0;
    step();

    // rd and wr together behave as a write
    cpu_addr = 32'hF010_0000; cpu_rd = 1'b1; cpu_wr = 1'b1;
    step();
    chk("both_wr",  32'(dev_wr),  32'h1);
    chk("both_rd",  32'(dev_rd),  32'h0);
    chk("both_sel", 32'(dev_sel), 32'h0008);
    dev_ready = 16'h0008;
    step();
    step();
    chk("both_done_stall", 32'(cpu_stall), 32'h0);
    cpu_rd = 1'b0; cpu_wr = 1'b0; dev_ready = '0;
    step();

    // Timer load: foreign ready on slot 3 must be ignored
    cpu_addr = 32'hF060_0000; cpu_rd = 1'b1;
    dev_rdata[32*3 +: 32] = 32'hDEAD_DEAD; dev_rdata[32*9 +: 32] = 32'hCAFE_F00D;
    step();
    chk("tmr_req_sel", 32'(dev_sel), 32'h0200);
    step();
    dev_ready = 16'h0008;
    step();
    chk("tmr_foreign1_stall", 32'(cpu_stall), 32'h1);
    step();
    chk("tmr_foreign2_stall", 32'(cpu_stall), 32'h1);
    chk("tmr_foreign_rdata",  cpu_rdata,      32'h1234_5678);
    dev_ready = 16'h0200;
    step();
    chk("tmr_done_stall", 32'(cpu_stall), 32'h0);
    chk("tmr_done_rdata", cpu_rdata,      32'hCAFE_F00D);
    cpu_rd = 1'b0; dev_ready = '0;
    step();

    // SSEG load with ready withheld
    cpu_addr = 32'hF0A0_0000; cpu_rd = 1'b1;
    step();
    chk("sseg_req_sel",  32'(dev_sel), 32'h0400);
    chk("sseg_req_addr", dev_addr,     32'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("sseg_wait_stall", 32'(cpu_stall), 32'h1);
      chk("sseg_wait_err",   32'(bus_err),   32'h0);
      step();
    end
`ifdef BUS_TIMEOUT_EN
    chk("tmo_done_stall", 32'(cpu_stall), 32'h0);
    chk("tmo_done_err",   32'(bus_err),   32'h1);
    chk("tmo_done_rdata", cpu_rdata,      32'h0);
    step();
    chk("tmo_idle_err",   32'(bus_err),   32'h0);
    chk("tmo_idle_stall", 32'(cpu_stall), 32'h1);
    step();
    chk("tmo_rereq_sel",  32'(dev_sel),   32'h0400);
    chk("tmo_rereq_rd",   32'(dev_rd),    32'h1);
    step();
`else
    for (int k = 0; k < 6; k++) begin
      chk("notmo_stall", 32'(cpu_stall), 32'h1);
      chk("notmo_err",   32'(bus_err),   32'h0);
      step();
    end
`endif

    // Reset in WAIT abandons the transaction
    rst = 1'b1;
    #1;
    chk("arst_stall", 32'(cpu_stall), 32'h0);
    chk("arst_sel",   32'(dev_sel),   32'h0);
    chk("arst_rd",    32'(dev_rd),    32'h0);
    chk("arst_rdata", cpu_rdata,      32'h0);
    step();
    chk("arst_hold_stall", 32'(cpu_stall), 32'h0);
    chk("arst_hold_rd",    32'(dev_rd),    32'h0);
    rst = 1'b0; cpu_addr = 32'h1000_0100;
    dev_rdata[32*1 +: 32] = 32'h0BAD_BEEF; dev_ready = 16'h0002;
    step();
    chk("post_req_sel",  32'(dev_sel), 32'h0002);
    chk("post_req_addr", dev_addr,     32'h0000_0100);
    chk("post_req_rd",   32'(dev_rd),  32'h1);
    step();
    step();
    chk("post_done_stall", 32'(cpu_stall), 32'h0);
    chk("post_done_rdata", cpu_rdata,      32'h0BAD_BEEF);
    cpu_rd = 1'b0; dev_ready = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
